// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared FSM states, segment constants and digit glyphs for the 7-seg path
package display_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, FORMAT} state_t;

  // Segment bit order is {g,f,e,d,c,b,a}; patterns here are lit-high, polarity applied per digit.
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_DASH  = 7'h40;

  function automatic logic [6:0] glyph(input logic [3:0] code);
    case (code)
      4'h0: glyph = 7'h3F;
      4'h1: glyph = 7'h06;
      4'h2: glyph = 7'h5B;
      4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;
      4'h5: glyph = 7'h6D;
      4'h6: glyph = 7'h7D;
      4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;
      4'h9: glyph = 7'h6F;
      4'hA: glyph = 7'h77;
      4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39;
      4'hD: glyph = 7'h5E;
      4'hE: glyph = 7'h79;
      default: glyph = 7'h71;
    endcase
  endfunction

endpackage

// File: rtl/seg7_nibble_dec.sv
// rtl/seg7_nibble_dec.sv - one digit: code + blank/dash flags to 7 segments (HEX_MODE_EN enables A-F)
module seg7_nibble_dec #(
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic [3:0] code,
  input  logic       blank,
  input  logic       dash,
  output logic [6:0] seg
);
  import display_pkg::*;

  logic [6:0] lit;

  always_comb begin
    if (dash)
      lit = SEG_DASH;
    else if (blank)
      lit = SEG_BLANK;
`ifdef HEX_MODE_EN
    else
      lit = glyph(code);
`else
    else if (code > 4'd9)
      lit = SEG_BLANK;
    else
      lit = glyph(code);
`endif
  end

  assign seg = (SEG_ACTIVE_LOW != 0) ? ~lit : lit;

endmodule

// File: rtl/bcd_display_ctrl.sv
// rtl/bcd_display_ctrl.sv - sequential double-dabble BCD display driver (HEX_MODE_EN adds hex_md)
module bcd_display_ctrl #(
  parameter int DATA_W         = 32,
  parameter int DIGITS         = 8,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  valid,
  input  logic [DATA_W-1:0]     valor,
  input  logic                  signed_md,
`ifdef HEX_MODE_EN
  input  logic                  hex_md,
`endif
  output logic                  busy,
  output logic                  done,
  output logic                  neg,
  output logic                  overflow,
  output logic [7*DIGITS-1:0]   segs
);
  import display_pkg::*;

  localparam int BW = 4 * (DIGITS + 2);
  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [7*DIGITS-1:0] SEGS_OFF = {(7*DIGITS){SEG_ACTIVE_LOW != 0}};

  state_t              state;
  logic [DATA_W-1:0]   val_r, pend_val, mag;
  logic                sm_r, pend_sm, pending_v, sign_r;
  logic [BW-1:0]       bcd, bcd_adj;
  logic [CW-1:0]       cnt;
  logic                ovf;
  int                  msd;
  logic [DIGITS-1:0]   blank_v, dash_v;
  logic [7*DIGITS-1:0] seg_next;
`ifdef HEX_MODE_EN
  localparam int HW = DATA_W + 4 * DIGITS;
  logic          hex_r, pend_hex, hex_ovf_r;
  logic [HW-1:0] hex_wide;
  assign hex_wide = {{(4*DIGITS){1'b0}}, val_r};
`endif

  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < DIGITS + 2; i++)
      if (bcd[4*i +: 4] >= 4'd5)
        bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
  end

  // Guard nibbles catch >DIGITS decimal digits; a sign needs the top digit free.
  always_comb begin
    msd = 0;
    for (int i = 1; i < DIGITS; i++)
      if (bcd[4*i +: 4] != 4'd0) msd = i;
    ovf = (bcd[BW-1 -: 8] != 8'd0) || (sign_r && (bcd[4*DIGITS-1 -: 4] != 4'd0));
`ifdef HEX_MODE_EN
    ovf = ovf || hex_ovf_r;
`endif
    blank_v = '0;
    dash_v  = '0;
    for (int i = 0; i < DIGITS; i++) begin
      blank_v[i] = (i > msd);
      dash_v[i]  = ovf || (sign_r && (i == msd + 1));
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    seg7_nibble_dec #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_dec (
      .code  (bcd[4*g +: 4]),
      .blank (blank_v[g]),
      .dash  (dash_v[g]),
      .seg   (seg_next[7*g +: 7])
    );
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      neg       <= 1'b0;
      overflow  <= 1'b0;
      segs      <= SEGS_OFF;
      pending_v <= 1'b0;
      pend_val  <= '0;
      pend_sm   <= 1'b0;
      val_r     <= '0;
      sm_r      <= 1'b0;
      sign_r    <= 1'b0;
      mag       <= '0;
      bcd       <= '0;
      cnt       <= '0;
`ifdef HEX_MODE_EN
      hex_r     <= 1'b0;
      pend_hex  <= 1'b0;
      hex_ovf_r <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (valid && state != IDLE) begin
        pending_v <= 1'b1;
        pend_val  <= valor;
        pend_sm   <= signed_md;
`ifdef HEX_MODE_EN
        pend_hex  <= hex_md;
`endif
      end
      case (state)
        IDLE: begin
          if (valid) begin
            val_r     <= valor;
            sm_r      <= signed_md;
`ifdef HEX_MODE_EN
            hex_r     <= hex_md;
`endif
            pending_v <= 1'b0;
            busy      <= 1'b1;
            state     <= LOAD;
          end else if (pending_v) begin
            val_r     <= pend_val;
            sm_r      <= pend_sm;
`ifdef HEX_MODE_EN
            hex_r     <= pend_hex;
`endif
            pending_v <= 1'b0;
            busy      <= 1'b1;
            state     <= LOAD;
          end
        end
        LOAD: begin
          sign_r <= sm_r && val_r[DATA_W-1];
          mag    <= (sm_r && val_r[DATA_W-1]) ? (~val_r) + DATA_W'(1) : val_r;
          bcd    <= '0;
          cnt    <= CW'(DATA_W);
          state  <= SHIFT;
`ifdef HEX_MODE_EN
          hex_ovf_r <= 1'b0;
          if (hex_r) begin
            sign_r    <= 1'b0;
            bcd       <= {8'd0, hex_wide[4*DIGITS-1:0]};
            hex_ovf_r <= |(hex_wide >> (4*DIGITS));
            state     <= FORMAT;
          end
`endif
        end
        SHIFT: begin
          {bcd, mag} <= {bcd_adj, mag} << 1;
          cnt        <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= FORMAT;
        end
        default: begin
          segs     <= seg_next;
          neg      <= sign_r;
          overflow <= ovf;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_display_ctrl.sv
// tb/tb_bcd_display_ctrl.sv - scoreboard bench for bcd_display_ctrl (HEX_MODE_EN adds the hex case)
module tb_bcd_display_ctrl;
  localparam int DATA_W = 32;
  localparam int DIGITS = 8;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              valid = 1'b0;
  logic [31:0]       valor = '0;
  logic              signed_md = 1'b0;
  logic              busy, done, neg, overflow;
  logic [55:0]       segs;
`ifdef HEX_MODE_EN
  logic              hex_md = 1'b0;
`endif

  bcd_display_ctrl #(.DATA_W(DATA_W), .DIGITS(DIGITS), .SEG_ACTIVE_LOW(1)) dut (
    .clock     (clock),
    .reset     (reset),
    .valid     (valid),
    .valor     (valor),
    .signed_md (signed_md),
`ifdef HEX_MODE_EN
    .hex_md    (hex_md),
`endif
    .busy      (busy),
    .done      (done),
    .neg       (neg),
    .overflow  (overflow),
    .segs      (segs)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [55:0] segs;
    logic        neg;
    logic        ovf;
    int          cyc;
  } exp_t;

  exp_t sbq[$];
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Lit-high glyphs {g,f,e,d,c,b,a}; 16 = dash, 17 = blank.
  function automatic logic [6:0] lit(input int d);
    case (d)
      0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
      4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
      8: return 7'h7F;  9: return 7'h6F;  10: return 7'h77; 11: return 7'h7C;
      12: return 7'h39; 13: return 7'h5E; 14: return 7'h79; 15: return 7'h71;
      16: return 7'h40;
      default: return 7'h00;
    endcase
  endfunction

  function automatic exp_t model(input logic [31:0] v, input logic sm, input int at);
    exp_t e;
    longint mag, t;
    int nd, g;
    bit ng;
    ng  = sm && v[31];
    mag = ng ? (64'h1_0000_0000 - {32'd0, v}) : {32'd0, v};
    nd = 1;
    t = mag;
    while (t >= 10) begin t = t / 10; nd++; end
    e.neg = ng;
    e.ovf = (nd + int'(ng)) > DIGITS;
    t = mag;
    for (int i = 0; i < DIGITS; i++) begin
      if (e.ovf)                g = 16;
      else if (i < nd)          g = int'(t % 10);
      else if (ng && i == nd)   g = 16;
      else                      g = 17;
      t = t / 10;
      e.segs[7*i +: 7] = ~lit(g);
    end
    e.cyc = at;
    return e;
  endfunction

  logic        rst_q = 1'b1;
  logic [55:0] shown_segs = '1;
  logic        shown_neg = 1'b0, shown_ovf = 1'b0;

  always @(negedge clock) begin
    exp_t e;
    if (rst_q) begin
      shown_segs = '1;
      shown_neg  = 1'b0;
      shown_ovf  = 1'b0;
    end
    if (done === 1'b1) begin
      if (sbq.size() == 0) begin
        check("unexpected_done", done, 0);
      end else begin
        e = sbq.pop_front();
        check("segs", segs, e.segs);
        check("neg", neg, e.neg);
        check("overflow", overflow, e.ovf);
        check("done_cycle", cyc, e.cyc);
        shown_segs = e.segs;
        shown_neg  = e.neg;
        shown_ovf  = e.ovf;
      end
    end else begin
      check("hold_segs", segs, shown_segs);
      check("hold_neg", neg, shown_neg);
      check("hold_ovf", overflow, shown_ovf);
    end
    rst_q = reset;
  end

  task automatic pulse(input logic [31:0] v, input logic sm, input int at);
    while (cyc < at - 1) begin @(posedge clock); #2; end
    valid = 1'b1; valor = v; signed_md = sm;
    @(posedge clock); #2;
    valid = 1'b0;
  endtask

  task automatic send(input logic [31:0] v, input logic sm);
    int k;
    k = cyc + 2;
    sbq.push_back(model(v, sm, k + DATA_W + 2));
    pulse(v, sm, k);
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 400) begin @(posedge clock); n++; end
    @(negedge clock);
    check("drain_pending", sbq.size(), 0);
    sbq.delete();
    check("idle_busy", busy, 0);
  endtask

  logic [31:0] dir_v [9] = '{32'd12345, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd99999999,
                             32'd100000000, 32'hFF67_6981, 32'hFF67_6980, 32'd0, 32'h8000_0000};
  logic        dir_s [9] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

  initial begin
    int k;
    logic [31:0] v;
    repeat (2) @(posedge clock);
    #2 reset = 1'b0;
    @(negedge clock);
    check("rst_segs", segs, 56'hFF_FFFF_FFFF_FFFF);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_neg", neg, 0);
    check("rst_ovf", overflow, 0);

    for (int i = 0; i < 9; i++) begin
      send(dir_v[i], dir_s[i]);
      drain();
    end

    // 6 is overwritten in the pending buffer by 7 before the first frame finishes.
    k = cyc + 2;
    sbq.push_back(model(32'd5, 1'b0, k + DATA_W + 2));
    sbq.push_back(model(32'd7, 1'b0, k + 2 * DATA_W + 5));
    pulse(32'd5, 1'b0, k);
    pulse(32'd6, 1'b0, k + 3);
    pulse(32'd7, 1'b0, k + 10);
    drain();

    for (int i = 0; i < 25; i++) begin
      case ($urandom_range(0, 3))
        0:       v = $urandom;
        1:       v = $urandom_range(0, 99999999);
        2:       v = 32'd0 - 32'($urandom_range(0, 12000000));
        default: v = $urandom_range(0, 999);
      endcase
      send(v, 1'($urandom_range(0, 1)));
      drain();
    end

    // Reset at edge k+15 aborts the frame and drops the queued value.
    k = cyc + 2;
    pulse(32'd123, 1'b0, k);
    pulse(32'd456, 1'b0, k + 3);
    while (cyc < k + 14) begin @(posedge clock); #2; end
    reset = 1'b1;
    @(posedge clock); #2;
    @(posedge clock); #2;
    reset = 1'b0;
    @(negedge clock);
    check("abort_segs", segs, 56'hFF_FFFF_FFFF_FFFF);
    check("abort_busy", busy, 0);
    repeat (80) @(posedge clock);
    @(negedge clock);
    check("abort_no_restart", busy, 0);

`ifdef HEX_MODE_EN
    begin
      exp_t e;
      k = cyc + 2;
      e.segs = {4{~lit(17)}} & 56'hFF_FFFF_F000_0000 | {28'hFFF_FFFF, ~lit(11), ~lit(14), ~lit(14), ~lit(15)};
      e.neg = 1'b0;
      e.ovf = 1'b0;
      e.cyc = k + 2;
      sbq.push_back(e);
      hex_md = 1'b1;
      pulse(32'h0000_BEEF, 1'b0, k);
      hex_md = 1'b0;
      drain();
    end
`endif

    check("final_queue", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
